// File: rtl/lock_reset_sequencer.sv
// lock_reset_sequencer
//   Qualifies the PCIe MMCM lock and the DDR ready/lock, then releases the
//   downstream reset. Both locks must be high for HOLD_CYCLES consecutive
//   cycles before release. Losing either lock, or a soft_rst pulse, goes back
//   to WAIT_LOCK and qualification starts again.
//
// Parameters
//   HOLD_CYCLES : number of consecutive stable cycles required (2..65535)
//   HB_WIDTH    : heartbeat counter width (>= 2); its two MSBs drive LEDs
//
// Optional feature
//   LOCK_LOSS_COUNTER_EN : when defined, lock_loss_cnt is a saturating count
//                          of RELEASED -> WAIT_LOCK drops caused by a lost
//                          lock. When undefined it is tied to 8'h00.
//
// Ports
//   pcie_clk_125MHz  in   single clock, rising edge
//   sys_rst_n        in   asynchronous active-low reset
//   pcie_mmcm_locked in   PCIe MMCM lock (asynchronous)
//   ddr_mmcm_locked  in   DDR ready/lock (asynchronous)
//   soft_rst         in   synchronous re-sequence request, active high
//   mmcms_locked     out  qualified combined lock (registered)
//   logic_rst        out  active-high downstream reset = ~mmcms_locked
//   status_leds[7:0] out  {hb[msb:msb-1], stable, locked, ddr, pcie, rst_up, 1}
//   lock_loss_cnt    out  saturating lock-loss count (or 0)
module lock_reset_sequencer #(
    parameter int HOLD_CYCLES = 1024,
    parameter int HB_WIDTH    = 28
) (
    input  logic       pcie_clk_125MHz,
    input  logic       sys_rst_n,
    input  logic       pcie_mmcm_locked,
    input  logic       ddr_mmcm_locked,
    input  logic       soft_rst,
    output logic       mmcms_locked,
    output logic       logic_rst,
    output logic [7:0] status_leds,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASED  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t              state, state_nxt;
    logic [1:0]          pcie_meta, ddr_meta;
    logic                pcie_sync, ddr_sync, both_sync;
    logic [15:0]         hold_cnt, hold_nxt;
    logic                locked_nxt;
    logic                rst_up;
    logic [HB_WIDTH-1:0] hb;

    // Two-flop synchronisers; stage [1] is the usable copy.
    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pcie_meta <= 2'b00;
            ddr_meta  <= 2'b00;
        end else begin
            pcie_meta <= {pcie_meta[0], pcie_mmcm_locked};
            ddr_meta  <= {ddr_meta[0], ddr_mmcm_locked};
        end
    end

    assign pcie_sync = pcie_meta[1];
    assign ddr_sync  = ddr_meta[1];
    assign both_sync = pcie_sync & ddr_sync;

    // State register
    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= WAIT_LOCK;
        else            state <= state_nxt;
    end

    // Next-state logic; soft_rst overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (soft_rst) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (both_sync) state_nxt = STABLE;
                STABLE: begin
                    if (!both_sync)                 state_nxt = WAIT_LOCK;
                    else if (hold_cnt == HOLD_LAST) state_nxt = RELEASED;
                end
                RELEASED:  if (!both_sync) state_nxt = WAIT_LOCK;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Output / datapath decode. The hold counter only advances while staying
    // in STABLE and is zero on every entry, so it tops out at HOLD_LAST and
    // cannot wrap.
    always_comb begin
        hold_nxt   = 16'd0;
        locked_nxt = (state_nxt == RELEASED);
        if (state == STABLE && state_nxt == STABLE) hold_nxt = hold_cnt + 16'd1;
    end

    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt     <= 16'd0;
            mmcms_locked <= 1'b0;
            rst_up       <= 1'b0;
            hb           <= '0;
        end else begin
            hold_cnt     <= hold_nxt;
            mmcms_locked <= locked_nxt;
            rst_up       <= 1'b1;
            hb           <= hb + HB_WIDTH'(1);
        end
    end

    assign logic_rst   = ~mmcms_locked;
    assign status_leds = {hb[HB_WIDTH-1 -: 2], (state == STABLE), mmcms_locked,
                          ddr_sync, pcie_sync, rst_up, 1'b1};

`ifdef LOCK_LOSS_COUNTER_EN
    // A drop from RELEASED counts only when caused by a lock, not soft_rst.
    logic       loss_evt;
    logic [7:0] loss_cnt;

    assign loss_evt = (state == RELEASED) && !both_sync && !soft_rst;

    always_ff @(posedge pcie_clk_125MHz or negedge sys_rst_n) begin
        if (!sys_rst_n)                       loss_cnt <= 8'h00;
        else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'h01;
    end

    assign lock_loss_cnt = loss_cnt;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lock_reset_sequencer.sv
module tb_lock_reset_sequencer;

    localparam int HOLD = 16;
    localparam int HBW  = 4;

    localparam int K_LK   = 0;
    localparam int K_RST  = 1;
    localparam int K_CNT  = 2;
    localparam int K_LEDS = 3;

    logic       pcie_clk_125MHz = 1'b0;
    logic       sys_rst_n, pcie_mmcm_locked, ddr_mmcm_locked, soft_rst;
    logic       mmcms_locked, logic_rst;
    logic [7:0] status_leds, lock_loss_cnt;

    lock_reset_sequencer #(.HOLD_CYCLES(HOLD), .HB_WIDTH(HBW)) dut (
        .pcie_clk_125MHz (pcie_clk_125MHz),
        .sys_rst_n       (sys_rst_n),
        .pcie_mmcm_locked(pcie_mmcm_locked),
        .ddr_mmcm_locked (ddr_mmcm_locked),
        .soft_rst        (soft_rst),
        .mmcms_locked    (mmcms_locked),
        .logic_rst       (logic_rst),
        .status_leds     (status_leds),
        .lock_loss_cnt   (lock_loss_cnt)
    );

    always #5 pcie_clk_125MHz = ~pcie_clk_125MHz;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] exp;
        string      tag;
    } sb_t;

    sb_t        sb[$];
    int         edge_n   = 0;
    int         rst_base = 0;
    int         total    = 0;
    int         bad      = 0;
    int         e;
    int         mon_i;
    logic [7:0] exp_cnt  = 8'h00;

    always @(posedge pcie_clk_125MHz) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int at, input int kind, input logic [7:0] exp, input string tag);
        sb_t s;
        s.at = at; s.kind = kind; s.exp = exp; s.tag = tag;
        sb.push_back(s);
    endtask

    function automatic logic [7:0] obs_of(input int kind);
        case (kind)
            K_LK:    return {7'd0, mmcms_locked};
            K_RST:   return {7'd0, logic_rst};
            K_CNT:   return lock_loss_cnt;
            default: return status_leds;
        endcase
    endfunction

    // Heartbeat model: hb counts edges since the last reset release.
    function automatic logic [7:0] led_exp(input int at, input bit st, input bit lk,
                                           input bit d, input bit p);
        logic [3:0] h;
        h = 4'(at - rst_base);
        return {h[3:2], st, lk, d, p, 1'b1, 1'b1};
    endfunction

    task automatic bump();
`ifdef LOCK_LOSS_COUNTER_EN
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
`endif
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pcie_clk_125MHz);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        check("sb_drain", 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    // Scoreboard monitor: compares entries due at the latest edge.
    always @(negedge pcie_clk_125MHz) begin
        mon_i = 0;
        while (mon_i < sb.size()) begin
            if (sb[mon_i].at < edge_n) begin
                check({"stale_", sb[mon_i].tag}, 8'd1, 8'd0);
                sb.delete(mon_i);
            end else if (sb[mon_i].at == edge_n) begin
                check(sb[mon_i].tag, obs_of(sb[mon_i].kind), sb[mon_i].exp);
                sb.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0; pcie_mmcm_locked = 1'b0; ddr_mmcm_locked = 1'b0; soft_rst = 1'b0;
        #3;
        check("rst_locked", {7'd0, mmcms_locked}, 8'h00);
        check("rst_logic_rst", {7'd0, logic_rst}, 8'h01);
        check("rst_leds", status_leds, 8'h01);
        check("rst_cnt", lock_loss_cnt, 8'h00);

        // Release reset and raise both locks together
        step(1);
        sys_rst_n = 1'b1; rst_base = edge_n;
        pcie_mmcm_locked = 1'b1; ddr_mmcm_locked = 1'b1; e = edge_n;
        push(e + 2,  K_LEDS, led_exp(e + 2, 0, 0, 1, 1), "leds_synced");
        push(e + 3,  K_LEDS, led_exp(e + 3, 1, 0, 1, 1), "leds_stable");
        push(e + 18, K_LK, 8'd0, "lk_before_hold");
        push(e + 19, K_LK, 8'd1, "lk_rise_19");
        push(e + 19, K_RST, 8'd0, "logic_rst_fall_19");
        push(e + 19, K_LEDS, led_exp(e + 19, 0, 1, 1, 1), "leds_released");
        drain(); step(2);

        // PCIe lock lost for 5 cycles while released
        e = edge_n; pcie_mmcm_locked = 1'b0; bump();
        push(e + 2, K_LK, 8'd1, "lk_hold_2");
        push(e + 3, K_LK, 8'd0, "lk_drop_3");
        push(e + 3, K_RST, 8'd1, "logic_rst_drop_3");
        push(e + 3, K_CNT, exp_cnt, "cnt_loss_1");
        push(e + 3, K_LEDS, led_exp(e + 3, 0, 0, 1, 0), "leds_pcie_lost");
        step(5); pcie_mmcm_locked = 1'b1;
        push(e + 23, K_LK, 8'd0, "lk_requal_pre");
        push(e + 24, K_LK, 8'd1, "lk_requal");
        drain(); step(2);

        // One-cycle soft reset while released
        e = edge_n; soft_rst = 1'b1;
        push(e,      K_LK, 8'd1, "lk_before_soft");
        push(e + 1,  K_LK, 8'd0, "lk_soft_drop");
        push(e + 1,  K_CNT, exp_cnt, "cnt_soft_unchanged");
        push(e + 1,  K_LEDS, led_exp(e + 1, 0, 0, 1, 1), "leds_soft_wait");
        step(1); soft_rst = 1'b0;
        push(e + 17, K_LK, 8'd0, "lk_soft_pre");
        push(e + 18, K_LK, 8'd1, "lk_soft_rerelease");
        drain(); step(2);

        // Drop both locks, then a one-cycle DDR glitch during qualification
        e = edge_n; pcie_mmcm_locked = 1'b0; ddr_mmcm_locked = 1'b0; bump();
        push(e + 3, K_LK, 8'd0, "lk_both_drop");
        push(e + 3, K_CNT, exp_cnt, "cnt_loss_2");
        step(5);
        e = edge_n; pcie_mmcm_locked = 1'b1; ddr_mmcm_locked = 1'b1;
        push(e + 19, K_LK, 8'd0, "lk_glitch_no_19");
        push(e + 29, K_LK, 8'd0, "lk_glitch_pre_30");
        push(e + 30, K_LK, 8'd1, "lk_glitch_30");
        step(10); ddr_mmcm_locked = 1'b0;
        step(1);  ddr_mmcm_locked = 1'b1;
        drain(); step(2);

        // 300 lock losses: counter saturates
        for (int i = 0; i < 300; i++) begin
            e = edge_n; pcie_mmcm_locked = 1'b0; bump();
            push(e + 3, K_CNT, exp_cnt, "cnt_sat_loop");
            push(e + 3, K_LK, 8'd0, "lk_sat_loop");
            step(1); pcie_mmcm_locked = 1'b1;
            step(22);
        end
        drain();
`ifdef LOCK_LOSS_COUNTER_EN
        check("cnt_saturated", lock_loss_cnt, 8'hFF);
`else
        check("cnt_disabled", lock_loss_cnt, 8'h00);
`endif
        check("lk_before_async_rst", {7'd0, mmcms_locked}, 8'h01);

        // Asynchronous reset while released: no clock edge needed
        #1; sys_rst_n = 1'b0; #1;
        check("arst_rel_locked", {7'd0, mmcms_locked}, 8'h00);
        check("arst_rel_logic_rst", {7'd0, logic_rst}, 8'h01);
        check("arst_rel_leds", status_leds, 8'h01);
        check("arst_rel_cnt", lock_loss_cnt, 8'h00);
        exp_cnt = 8'h00;

        // Asynchronous reset mid-STABLE
        step(2); sys_rst_n = 1'b1; rst_base = edge_n;
        step(8);
        check("leds_mid_stable", status_leds, led_exp(edge_n, 1, 0, 1, 1));
        #1; sys_rst_n = 1'b0; #1;
        check("arst_stb_locked", {7'd0, mmcms_locked}, 8'h00);
        check("arst_stb_logic_rst", {7'd0, logic_rst}, 8'h01);
        check("arst_stb_leds", status_leds, 8'h01);

        // Heartbeat wrap with locks low
        pcie_mmcm_locked = 1'b0; ddr_mmcm_locked = 1'b0;
        step(1); sys_rst_n = 1'b1; rst_base = edge_n; e = edge_n;
        push(e + 1,  K_LEDS, led_exp(e + 1, 0, 0, 0, 0), "hb_1");
        push(e + 15, K_LEDS, led_exp(e + 15, 0, 0, 0, 0), "hb_15");
        push(e + 16, K_LEDS, led_exp(e + 16, 0, 0, 0, 0), "hb_wrap_0");
        push(e + 20, K_LEDS, led_exp(e + 20, 0, 0, 0, 0), "hb_4");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
